// File: rtl/rx_line_pkg.sv
// Shared constants and state encoding for the receive line assembler.
// Imported by rx_line_asm and by the TX/command blocks that reuse the edge detector.
package rx_line_pkg;

   localparam logic [7:0] CHAR_LF   = 8'h0A;
   localparam logic [7:0] CHAR_CR   = 8'h0D;
   localparam logic [7:0] CHAR_BS   = 8'h08;
   localparam logic [7:0] CHAR_DEL  = 8'h7F;
   localparam logic [7:0] PRINT_MIN = 8'h20;
   localparam logic [7:0] PRINT_MAX = 8'h7E;

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      ACTIVE  = 3'b010,
      SKIP_LF = 3'b100
   } state_t;

endpackage

// File: rtl/rx_edge_detect.sv
// Rising-edge detector; history resets to 1 so a level held high
// through reset is not reported as an edge.
module rx_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clock) begin
      if (!reset) level_q <= 1'b1;
      else        level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/rx_line_asm.sv
// Assembles received bytes into a NUL-terminated line in RAM, with
// CR/LF/CRLF terminators, backspace editing and overflow reporting.
module rx_line_asm
   import rx_line_pkg::*;
#(
   parameter  int ADDR_W  = 8,
   parameter  int MAX_LEN = 254,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data,
   output logic              write,
   output logic              line_done,
   output logic [LEN_W-1:0]  line_len,
   output logic              overflow
);

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic              event_rx;

   rx_edge_detect u_edge (
      .clock (clock),
      .reset (reset),
      .level (rx_done),
      .rise  (event_rx)
   );

   logic is_lf, is_cr, is_term, is_bs, is_print, is_used;

   assign is_lf    = (rx_data == CHAR_LF);
   assign is_cr    = (rx_data == CHAR_CR);
   assign is_term  = is_lf | is_cr;
   assign is_bs    = (rx_data == CHAR_BS) | (rx_data == CHAR_DEL);
   assign is_print = (rx_data >= PRINT_MIN) && (rx_data <= PRINT_MAX);
   assign is_used  = is_term | is_bs | is_print;

   // A byte in SKIP_LF that is not the swallowed LF opens a fresh line.
   logic              new_line;
   logic [ADDR_W-1:0] cur_base;
   logic [LEN_W-1:0]  cur_len;
   logic [ADDR_W-1:0] wr_addr;

   assign new_line = (state == IDLE) || ((state == SKIP_LF) && !is_lf);
   assign cur_base = new_line ? start_addr : base;
   assign cur_len  = new_line ? '0 : line_len;
   assign wr_addr  = cur_base + ADDR_W'(cur_len);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         base      <= '0;
         addr      <= '0;
         data      <= '0;
         write     <= 1'b0;
         line_done <= 1'b0;
         line_len  <= '0;
         overflow  <= 1'b0;
      end else begin
         write     <= 1'b0;
         line_done <= 1'b0;
         if (event_rx) begin
            if ((state == SKIP_LF) && is_lf) begin
               state <= IDLE;
            end else if (is_used) begin
               if (new_line) begin
                  base     <= start_addr;
                  overflow <= 1'b0;
               end
               unique case (1'b1)
                  is_print: begin
                     state <= ACTIVE;
                     if (cur_len < LEN_W'(MAX_LEN)) begin
                        write    <= 1'b1;
                        addr     <= wr_addr;
                        data     <= rx_data;
                        line_len <= cur_len + LEN_W'(1);
                     end else begin
                        overflow <= 1'b1;
                        line_len <= cur_len;
                     end
                  end
                  is_bs: begin
                     if (new_line) state <= IDLE;
                     if (cur_len != '0) line_len <= cur_len - LEN_W'(1);
                     else               line_len <= cur_len;
                  end
                  is_term: begin
                     write     <= 1'b1;
                     addr      <= wr_addr;
                     data      <= 8'h00;
                     line_done <= 1'b1;
                     line_len  <= cur_len;
                     state     <= is_cr ? SKIP_LF : IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_line_asm.sv
// Directed bench for rx_line_asm with MAX_LEN=4 so overflow is reachable;
// every RAM write is logged and matched against hand-computed vectors.
module tb_rx_line_asm;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] start_addr = 8'h00;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b1;
   logic [7:0] addr;
   logic [7:0] data;
   logic       write;
   logic       line_done;
   logic [2:0] line_len;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   rx_line_asm #(.ADDR_W(8), .MAX_LEN(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_addr (start_addr),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .addr       (addr),
      .data       (data),
      .write      (write),
      .line_done  (line_done),
      .line_len   (line_len),
      .overflow   (overflow)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic       done;
      logic [2:0] len;
      logic       ovf;
   } wr_t;

   wr_t wq[$];

   always @(negedge clock) begin
      if (write) wq.push_back('{addr, data, line_done, line_len, overflow});
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic exp_w(input string tag, input int a, input int d);
      wr_t w;
      if (wq.size() == 0) begin
         chk({tag, " present"}, 0, 1);
      end else begin
         w = wq.pop_front();
         chk({tag, " addr"}, w.a, a);
         chk({tag, " data"}, w.d, d);
         chk({tag, " done"}, w.done, 0);
      end
   endtask

   task automatic exp_nul(input string tag, input int a, input int len, input int ovf);
      wr_t w;
      if (wq.size() == 0) begin
         chk({tag, " present"}, 0, 1);
      end else begin
         w = wq.pop_front();
         chk({tag, " addr"}, w.a, a);
         chk({tag, " data"}, w.d, 0);
         chk({tag, " done"}, w.done, 1);
         chk({tag, " len"}, w.len, len);
         chk({tag, " ovf"}, w.ovf, ovf);
      end
   endtask

   task automatic exp_empty(input string tag);
      chk({tag, " extra writes"}, wq.size(), 0);
      wq.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " addr"}, addr, 0);
      chk({tag, " data"}, data, 0);
      chk({tag, " write"}, write, 0);
      chk({tag, " line_done"}, line_done, 0);
      chk({tag, " line_len"}, line_len, 0);
      chk({tag, " overflow"}, overflow, 0);
   endtask

   initial begin
      // reset with rx_done held high: release must not create an event
      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset = 1'b1;
      repeat (3) @(negedge clock);
      exp_empty("held_high");
      rx_done = 1'b0;
      @(negedge clock);

      start_addr = 8'h10;
      send_str("AB\n");
      exp_w("l1_a", 8'h10, 8'h41);
      exp_w("l1_b", 8'h11, 8'h42);
      exp_nul("l1_nul", 8'h12, 2, 0);
      exp_empty("l1");

      start_addr = 8'h20;
      send_str("AB\r\nC\n");
      exp_w("crlf_a", 8'h20, 8'h41);
      exp_w("crlf_b", 8'h21, 8'h42);
      exp_nul("crlf_nul1", 8'h22, 2, 0);
      exp_w("crlf_c", 8'h20, 8'h43);
      exp_nul("crlf_nul2", 8'h21, 1, 0);
      exp_empty("crlf");

      start_addr = 8'h00;
      send_str("ABC");
      send_byte(8'h08);
      send_byte(8'h7F);
      send_byte(8'h01);
      send_str("Z\n");
      exp_w("bs_a", 0, 8'h41);
      exp_w("bs_b", 1, 8'h42);
      exp_w("bs_c", 2, 8'h43);
      exp_w("bs_z", 1, 8'h5A);
      exp_nul("bs_nul", 2, 2, 0);
      exp_empty("bs");

      send_str("ABCDEF\n");
      exp_w("ov_a", 0, 8'h41);
      exp_w("ov_b", 1, 8'h42);
      exp_w("ov_c", 2, 8'h43);
      exp_w("ov_d", 3, 8'h44);
      exp_nul("ov_nul", 4, 4, 1);
      exp_empty("ov");
      chk("ov_hold_len", line_len, 4);
      chk("ov_hold_ovf", overflow, 1);
      send_str("A\n");
      exp_w("ov2_a", 0, 8'h41);
      exp_nul("ov2_nul", 1, 1, 0);
      exp_empty("ov2");

      start_addr = 8'h50;
      send_str("\r\r\n");
      exp_nul("crcr_1", 8'h50, 0, 0);
      exp_nul("crcr_2", 8'h50, 0, 0);
      exp_empty("crcr");

      send_byte(8'h08);
      send_byte(8'h01);
      send_byte(8'h7F);
      exp_empty("idle_junk");
      start_addr = 8'h60;
      send_str("X\n");
      exp_w("junk_x", 8'h60, 8'h58);
      exp_nul("junk_nul", 8'h61, 1, 0);
      exp_empty("junk");

      start_addr = 8'hFE;
      send_str("A");
      start_addr = 8'h55;
      send_str("BC\n");
      exp_w("wrap_a", 8'hFE, 8'h41);
      exp_w("wrap_b", 8'hFF, 8'h42);
      exp_w("wrap_c", 8'h00, 8'h43);
      exp_nul("wrap_nul", 8'h01, 3, 0);
      exp_empty("wrap");

      start_addr = 8'h30;
      send_str("AB");
      exp_w("mid_a", 8'h30, 8'h41);
      exp_w("mid_b", 8'h31, 8'h42);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk_zero("mid_reset");
      reset = 1'b1;
      repeat (2) @(negedge clock);
      exp_empty("mid_no_nul");
      start_addr = 8'h40;
      send_str("Q\n");
      exp_w("post_q", 8'h40, 8'h51);
      exp_nul("post_nul", 8'h41, 1, 0);
      exp_empty("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_line_asm.md
# rx_line_asm

Parametrised line assembler that sits between the UART receiver and the line buffer RAM. It turns a stream of received bytes into a NUL-terminated string at a caller-supplied base address. It supports CR, LF and CRLF terminators, backspace/delete editing, a configurable maximum line length with overflow reporting, and a reported line length. It is the drop-in successor to the fixed 8-bit, LF-only line receiver used by the command parser path.

## Interface
- `ADDR_W`, 8: RAM address width; all address arithmetic is modulo 2^ADDR_W.
- `MAX_LEN`, 254: maximum stored characters per line, excluding the NUL. Requires MAX_LEN+1 ≤ 2^ADDR_W.
- `LEN_W`, $clog2(MAX_LEN+1): width of `line_len` (derived; do not override).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  active-low reset. Reset is synchronous to `clock`; one clock; no other clock domains.
- `start_addr`  in  ADDR_W  base address of the next line. Latched at the first accepted byte of each line.
- `rx_data`  in  8  received byte. Must be valid when `rx_done` rises.
- `rx_done`  in  1  UART byte-complete level. Only its rising edge is significant.
- `addr`  out  ADDR_W  RAM write address.
- `data`  out  8  RAM write data.
- `write`  out  1  RAM write strobe, one cycle per write.
- `line_done`  out  1  one-cycle pulse; the line is complete and its NUL is written.
- `line_len`  out  LEN_W  stored characters in the current line; final value valid while `line_done`=1.
- `overflow`  out  1  at least one printable byte was dropped in the current line; valid while `line_done`=1.

## Operation
- Byte event = `rx_done`=1 and registered `rx_done_q`=0. `rx_done_q` resets to 1, so `rx_done` held high through reset is not an event.
- Byte classes:
  - LF 0x0A and CR 0x0D are terminators.
  - BS 0x08 and DEL 0x7F are backspace.
  - 0x20–0x7E are printable.
  - Everything else is ignored: no write and no state change.
- FSM states: IDLE, ACTIVE, SKIP_LF.
- IDLE, on a byte event:
  - Latch `start_addr` into `base`; clear `line_len` and `overflow`.
  - Process the byte as ACTIVE would, except that backspace and ignored bytes leave the FSM in IDLE.
- ACTIVE, on a byte event:
  - Printable with `line_len` < MAX_LEN: `addr`=`base`+`line_len`, `data`=byte, `write`=1, `line_len`++.
  - Printable with `line_len` = MAX_LEN: byte dropped, `overflow`←1 (sticky until the next line starts), no write.
  - Backspace: if `line_len`>0 then `line_len`--; no write; the stale RAM byte is overwritten later or sits beyond the NUL.
  - Terminator: `addr`=`base`+`line_len`, `data`=0x00, `write`=1, `line_done`=1. Next state is SKIP_LF if the byte was CR, otherwise IDLE.
- SKIP_LF, on a byte event:
  - LF is swallowed with no write, and the FSM goes to IDLE. CRLF therefore yields one line.
  - Any other byte is handled exactly as IDLE would handle it, in the same cycle.
- An empty line (terminator as the first byte) writes 0x00 at `start_addr`, with `line_len`=0.
- Consecutive CR CR gives two lines, the second one empty.
- Address wrap: `base`+`line_len` wraps modulo 2^ADDR_W; no error is raised.

## Timing
- Reset values:
  - `addr`=0, `data`=0, `write`=0, `line_done`=0, `line_len`=0, `overflow`=0.
  - State=IDLE, `rx_done_q`=1, `base`=0.
- Latency: a byte event sampled at edge E produces registered `write`/`addr`/`data`/`line_done` valid in the cycle after E, for exactly one cycle.
- `line_done` and the NUL `write` are asserted in the same cycle.
- `line_len` and `overflow` hold their values after `line_done` until the first byte event of the next line.
- Minimum byte spacing is 2 cycles (one cycle of `rx_done` low between events). Events arriving faster are undefined.
- Reset asserted mid-line: the partial line is abandoned and no NUL is written. The next byte after reset starts a new line at the current `start_addr`.
- A `start_addr` change mid-line has no effect until the next line.

## Structure
- Package `rx_line_pkg`:
  - Character constants: CHAR_LF, CHAR_CR, CHAR_BS, CHAR_DEL, PRINT_MIN=0x20, PRINT_MAX=0x7E.
  - State encoding, one-hot 3 bits: IDLE=001, ACTIVE=010, SKIP_LF=100.
- Sub-module `rx_edge_detect`: rising-edge detector with reset-to-1 history register. It is reusable by the TX and command blocks.
- Byte classification is combinational logic inside `rx_line_asm`.

## Test plan
- "AB\n", `start_addr`=0x10 → writes (0x10,0x41), (0x11,0x42), (0x12,0x00); `line_done` on the last write; `line_len`=2; `overflow`=0.
- "AB\r\nC\n", `start_addr`=0x20 → one line ending with (0x22,0x00) and `line_done`; the LF is swallowed; the second line writes (0x20,0x43), (0x21,0x00); `line_done` pulses twice in total.
- "ABC", BS, BS, "Z\n" at base 0 → writes 0x41, 0x42, 0x43 at 0..2, then (1,0x5A), (2,0x00); `line_len`=2.
- MAX_LEN=4: "ABCDEF\n" at base 0 → 4 data writes, then (4,0x00); `line_len`=4; `overflow`=1 with `line_done`. The next line reports `overflow`=0.
- `rx_done` held high through reset release → no write. BS or 0x01 as the first byte → no write, FSM stays IDLE.
- `start_addr`=0xFE, "ABC\n" → addresses 0xFE, 0xFF, 0x00, then NUL at 0x01. Reset asserted after "AB" of a later line → no NUL written; all outputs return to 0.
